// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between N_REQ requesters.
// The carry is kept in the sum MSB, and each result is held under a valid/ready output handshake.
module shared_adder_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_flat,
    input  logic [N_REQ*WIDTH-1:0] b_flat,
    output logic [N_REQ-1:0]       gnt,
    output logic                   sum_valid,
    output logic [WIDTH:0]         sum,
    output logic [ID_W-1:0]        sum_id,
    input  logic                   sum_ready,
    output logic                   state_dbg
);

    // Handshake: a result transfers on a rising edge where sum_valid && sum_ready;
    // requester i's operands are consumed on a rising edge where gnt[i] is high.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e           state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [WIDTH:0]   sum_q;
    logic [ID_W-1:0]  sum_id_q;

    logic [WIDTH:0]   sum_d;
    logic [ID_W-1:0]  sel_idx;
    logic [ID_W-1:0]  rr_next;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             found;
    logic             can_accept;
    logic             grant_en;

    assign can_accept = (state_q == ST_EMPTY) || sum_ready;

    // Search upward from rr_ptr_q, wrapping modulo N_REQ; N_REQ need not be a power of two.
    always_comb begin
        int cand;
        sel_idx = rr_ptr_q;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = ID_W'(cand);
            end
        end
    end

    // Reset gates the grant so no requester believes it was served while rst_n is low.
    assign grant_en = rst_n && can_accept && found;

    always_comb begin
        gnt = '0;
        if (grant_en) begin
            gnt[sel_idx] = 1'b1;
        end
    end

    assign rr_next = (sel_idx == ID_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

    assign a_sel = a_flat[sel_idx*WIDTH +: WIDTH];
    assign b_sel = b_flat[sel_idx*WIDTH +: WIDTH];
    assign sum_d = {1'b0, a_sel} + {1'b0, b_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            rr_ptr_q <= '0;
            sum_q    <= '0;
            sum_id_q <= '0;
        end else begin
            if (grant_en) begin
                sum_q    <= sum_d;
                sum_id_q <= sel_idx;
                rr_ptr_q <= rr_next;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (grant_en) begin
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // A grant in the same cycle as a drain replaces the result and stays FULL.
                    if (!grant_en && sum_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign sum_valid = (state_q == ST_FULL);
    assign sum       = sum_q;
    assign sum_id    = sum_id_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter: grant checks inline, results checked by a scoreboard monitor.
module tb_shared_adder_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_flat;
  logic [N_REQ*WIDTH-1:0] b_flat;
  logic [N_REQ-1:0]       gnt;
  logic                   sum_valid;
  logic [WIDTH:0]         sum;
  logic [ID_W-1:0]        sum_id;
  logic                   sum_ready;
  logic                   state_dbg;

  logic [WIDTH-1:0] a_v [N_REQ];
  logic [WIDTH-1:0] b_v [N_REQ];

  logic [ID_W+WIDTH:0] exp_q [$];
  int total;
  int bad;

  assign a_flat = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign b_flat = {b_v[3], b_v[2], b_v[1], b_v[0]};

  shared_adder_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .sum_valid (sum_valid),
    .sum       (sum),
    .sum_id    (sum_id),
    .sum_ready (sum_ready),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Checks gnt/sum_valid at the falling edge and, on an expected grant, queues the hand-computed result.
  task automatic cycle_chk(input logic [3:0] eg, input logic ev, input logic [8:0] es, input string nm);
    logic [ID_W-1:0] id;
    @(negedge clk);
    check({nm, " gnt"}, 32'(gnt), 32'(eg));
    check({nm, " valid"}, 32'(sum_valid), 32'(ev));
    if (eg != 4'b0000) begin
      id = '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (eg[i]) id = ID_W'(i);
      end
      exp_q.push_back({id, es});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
    a_v[idx] = a;
    b_v[idx] = b;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [ID_W+WIDTH:0] e;
    if (rst_n && sum_valid && sum_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result: got id=%0d sum=%0d, expected no result", sum_id, sum);
      end else begin
        e = exp_q.pop_front();
        if ({sum_id, sum} !== e) begin
          bad++;
          $display("FAIL result: got id=%0d sum=%0d expected id=%0d sum=%0d",
                   sum_id, sum, e[ID_W+WIDTH:WIDTH+1], e[WIDTH:0]);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    req = 4'b1111;
    sum_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_ops(i, 8'(10 * (i + 1)), 8'(i + 1));

    // reset state
    #2;
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst valid", 32'(sum_valid), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst id", 32'(sum_id), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // round robin with all requests held
    cycle_chk(4'b0001, 1'b0, 9'd11, "rr0");
    cycle_chk(4'b0010, 1'b1, 9'd22, "rr1");
    cycle_chk(4'b0100, 1'b1, 9'd33, "rr2");
    cycle_chk(4'b1000, 1'b1, 9'd44, "rr3");
    cycle_chk(4'b0001, 1'b1, 9'd11, "rr4");
    req = 4'b0000;
    cycle_chk(4'b0000, 1'b1, 9'd0, "rr drain");
    cycle_chk(4'b0000, 1'b0, 9'd0, "rr empty");

    // single requester
    set_ops(2, 8'd200, 8'd100);
    req = 4'b0100;
    cycle_chk(4'b0100, 1'b0, 9'd300, "single");
    req = 4'b0000;
    cycle_chk(4'b0000, 1'b1, 9'd0, "single drain");
    cycle_chk(4'b0000, 1'b0, 9'd0, "single empty");

    // back-pressure
    set_ops(0, 8'd50, 8'd60);
    set_ops(1, 8'd70, 8'd80);
    req = 4'b0011;
    cycle_chk(4'b0001, 1'b0, 9'd110, "bp first");
    sum_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle_chk(4'b0000, 1'b1, 9'd0, "bp stall");
      check("bp hold sum", 32'(sum), 32'd110);
      check("bp hold id", 32'(sum_id), 32'd0);
    end
    sum_ready = 1'b1;
    cycle_chk(4'b0010, 1'b1, 9'd150, "bp release");
    req = 4'b0000;
    cycle_chk(4'b0000, 1'b1, 9'd0, "bp drain");
    cycle_chk(4'b0000, 1'b0, 9'd0, "bp empty");

    // carry boundaries
    set_ops(2, 8'd255, 8'd255);
    req = 4'b0100;
    cycle_chk(4'b0100, 1'b0, 9'h1FE, "carry 255+255");
    set_ops(3, 8'd255, 8'd1);
    req = 4'b1000;
    cycle_chk(4'b1000, 1'b1, 9'd256, "carry 255+1");
    set_ops(0, 8'd0, 8'd0);
    req = 4'b0001;
    cycle_chk(4'b0001, 1'b1, 9'd0, "carry 0+0");
    req = 4'b0000;
    cycle_chk(4'b0000, 1'b1, 9'd0, "carry drain");
    cycle_chk(4'b0000, 1'b0, 9'd0, "carry empty");

    // mid-operation reset with a result in flight and the pointer at 2
    set_ops(1, 8'd5, 8'd6);
    req = 4'b0010;
    cycle_chk(4'b0010, 1'b0, 9'd11, "pre reset");
    check("pre reset valid", 32'(sum_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    req = 4'b1111;
    #1;
    check("mid rst valid", 32'(sum_valid), 32'd0);
    check("mid rst sum", 32'(sum), 32'd0);
    check("mid rst id", 32'(sum_id), 32'd0);
    check("mid rst gnt", 32'(gnt), 32'd0);
    exp_q.delete();
    set_ops(0, 8'd7, 8'd8);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle_chk(4'b0001, 1'b0, 9'd15, "post reset");
    req = 4'b0000;
    cycle_chk(4'b0000, 1'b1, 9'd0, "post drain");
    cycle_chk(4'b0000, 1'b0, 9'd0, "post empty");

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
